// File: rtl/mealy_rr_arbiter.sv
// Round-robin arbiter sharing one go/done-handshaked engine among NUM_REQ requesters.
// Optional watchdog abort of a stuck job is built when MEALY_ARB_TIMEOUT_EN is defined.
module mealy_rr_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] done,
  output logic               eng_go,
  input  logic               eng_done,
  output logic [NUM_REQ-1:0] err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               eng_go_q, eng_go_d;

  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   cand;
  logic               found;
  logic [IDX_W-1:0]   next_ptr;

`ifdef MEALY_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] err_q, err_d;
`endif

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    winner = ptr_q;
    cand   = ptr_q;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign next_ptr = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    eng_go_d = eng_go_q;
`ifdef MEALY_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = '0;
`endif
    case (state_q)
      IDLE: begin
        gnt_d    = '0;
        eng_go_d = 1'b0;
        if (found) begin
          owner_d  = winner;
          gnt_d    = NUM_REQ'(1) << winner;
          eng_go_d = 1'b1;
          state_d  = BUSY;
`ifdef MEALY_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      BUSY: begin
        eng_go_d = 1'b1;
        if (eng_done) begin
          done_d[owner_q] = 1'b1;
          eng_go_d        = 1'b0;
          ptr_d           = next_ptr;
          state_d         = RELEASE;
        end
`ifdef MEALY_ARB_TIMEOUT_EN
        // eng_done takes precedence over a watchdog expiry in the same cycle.
        else if (cnt_q == CNT_LIMIT) begin
          err_d[owner_q] = 1'b1;
          eng_go_d       = 1'b0;
          ptr_d          = next_ptr;
          state_d        = RELEASE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RELEASE: begin
        eng_go_d = 1'b0;
        if (!req[owner_q]) begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d    = '0;
        eng_go_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      eng_go_q <= 1'b0;
`ifdef MEALY_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      eng_go_q <= eng_go_d;
`ifdef MEALY_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign eng_go = eng_go_q;
`ifdef MEALY_ARB_TIMEOUT_EN
  assign err    = err_q;
`else
  assign err    = '0;
`endif

endmodule

// File: tb/tb_mealy_rr_arbiter.sv
// Self-checking bench for mealy_rr_arbiter: vector table plus hand-built corner sequences.
// Define MEALY_ARB_TIMEOUT_EN for both files to exercise the watchdog path.
module tb_mealy_rr_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [N-1:0] done;
  logic         eng_go;
  logic         eng_done;
  logic [N-1:0] err;

  always #5 clk = ~clk;

  mealy_rr_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .done     (done),
    .eng_go   (eng_go),
    .eng_done (eng_done),
    .err      (err)
  );

  typedef struct {
    logic [N-1:0] req;
    logic         eng_done;
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic         go;
    logic [N-1:0] err;
  } vec_t;

  typedef struct {
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic         go;
    logic [N-1:0] err;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got gnt/done/go/err=%b/%b/%b/%b expected %b/%b/%b/%b", name,
               act[12:9], act[8:5], act[4], act[3:0], exp[12:9], exp[8:5], exp[4], exp[3:0]);
    end
  endtask

  // Drive one cycle of inputs, queue the expected registered outputs, compare after the edge.
  task automatic apply(input string tag, input logic [N-1:0] r, input logic d,
                       input logic [N-1:0] g, input logic [N-1:0] dn, input logic go,
                       input logic [N-1:0] er);
    exp_t e;
    req      = r;
    eng_done = d;
    e.gnt = g; e.done = dn; e.go = go; e.err = er;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check(tag, {gnt, done, eng_go, err}, {e.gnt, e.done, e.go, e.err});
  endtask

  vec_t tbl[30];

  initial begin
    logic [N-1:0] oh;
    rst      = 1'b1;
    req      = 4'b1111;
    eng_done = 1'b0;

    // Build the round-robin job table: grant, 3 busy, done, release with owner's req low.
    for (int j = 0; j < 5; j++) begin
      oh = 4'b0001 << (j % N);
      tbl[j*6+0] = '{4'b1111,     1'b0, oh,      4'b0000, 1'b1, 4'b0000};
      tbl[j*6+1] = '{4'b1111,     1'b0, oh,      4'b0000, 1'b1, 4'b0000};
      tbl[j*6+2] = '{4'b1111,     1'b0, oh,      4'b0000, 1'b1, 4'b0000};
      tbl[j*6+3] = '{4'b1111,     1'b0, oh,      4'b0000, 1'b1, 4'b0000};
      tbl[j*6+4] = '{4'b1111,     1'b1, oh,      oh,      1'b0, 4'b0000};
      tbl[j*6+5] = '{4'b1111 & ~oh, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000};
    end

    repeat (5) begin
      @(posedge clk);
      #1;
      check("in_reset", {gnt, done, eng_go, err}, 13'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 30; i++)
      apply($sformatf("rr_%0d", i), tbl[i].req, tbl[i].eng_done,
            tbl[i].gnt, tbl[i].done, tbl[i].go, tbl[i].err);

    // Lone requester 2: grant holds through RELEASE until its req falls.
    apply("solo2_go",    4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0000);
    apply("solo2_busy",  4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0000);
    apply("solo2_done",  4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b0, 4'b0000);
    apply("solo2_hold1", 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0000);
    apply("solo2_hold2", 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0000);
    apply("solo2_rel",   4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    apply("solo2_idle",  4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000);

    // Requester 1 drops req mid-job: no abort, done still pulses, RELEASE lasts one cycle.
    apply("drop1_go",    4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0000);
    apply("drop1_busy1", 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0000);
    apply("drop1_busy2", 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0000);
    apply("drop1_done",  4'b0000, 1'b1, 4'b0010, 4'b0010, 1'b0, 4'b0000);
    apply("drop1_rel",   4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    apply("idle_done",   4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000);

    // Pointer now at 2: of req 0 and 3, requester 3 wins.
    apply("rr_ptr_go",   4'b1001, 1'b0, 4'b1000, 4'b0000, 1'b1, 4'b0000);
    apply("rr_ptr_busy", 4'b1001, 1'b0, 4'b1000, 4'b0000, 1'b1, 4'b0000);

    // Asynchronous reset mid-job, away from any clock edge.
    #2;
    req = 4'b1000;
    rst = 1'b1;
    #1;
    check("async_rst", {gnt, done, eng_go, err}, 13'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_hold", {gnt, done, eng_go, err}, 13'd0);
    end
    rst = 1'b0;
    apply("post_rst_go", 4'b1000, 1'b0, 4'b1000, 4'b0000, 1'b1, 4'b0000);

`ifdef MEALY_ARB_TIMEOUT_EN
    for (int i = 1; i < TO; i++)
      apply($sformatf("to_wait_%0d", i), 4'b1000, 1'b0, 4'b1000, 4'b0000, 1'b1, 4'b0000);
    apply("to_err",      4'b1000, 1'b0, 4'b1000, 4'b0000, 1'b0, 4'b1000);
`else
    apply("job3_busy1",  4'b1000, 1'b0, 4'b1000, 4'b0000, 1'b1, 4'b0000);
    apply("job3_busy2",  4'b1000, 1'b0, 4'b1000, 4'b0000, 1'b1, 4'b0000);
    apply("job3_done",   4'b1000, 1'b1, 4'b1000, 4'b1000, 1'b0, 4'b0000);
`endif
    apply("job3_rel",    4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    apply("next0_go",    4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0000);
    apply("next0_done",  4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0000);
    apply("next0_rel",   4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
